// File: rtl/program_loader.sv
// program_loader
//   Receives a program as a stream of UART bytes (high byte first, then low
//   byte per instruction word) and writes each word into program memory.
//   The load ends successfully on a HLT instruction (opcode 00000). It ends
//   in error on an illegal opcode, on program-memory overflow, or when the
//   low byte of a word does not arrive in time.
//
// Ports
//   i_clock      : clock, rising edge active
//   i_reset_n    : asynchronous active-low reset
//   i_start      : one-cycle request to arm a load (ignored while busy)
//   i_rx_data    : received byte
//   i_rx_valid   : one-cycle strobe qualifying i_rx_data
//   o_mem_addr   : program-memory write address
//   o_mem_data   : instruction word to write
//   o_mem_we     : one-cycle write-enable pulse
//   o_busy       : load in progress (WAIT_HI or WAIT_LO)
//   o_done       : program loaded and terminated by HLT
//   o_err        : 00 none, 01 bad opcode, 10 overflow, 11 timeout
//   o_count      : number of words written
//   o_cpu_en     : CPU run enable (mirrors o_done)
module program_loader #(
    parameter int OPCODE  = 5,
    parameter int OPERAND = 11,
    parameter int DEPTH   = 2048,
    parameter int TIMEOUT = 1000000
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic                        i_start,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_valid,
    output logic [$clog2(DEPTH)-1:0]    o_mem_addr,
    output logic [OPCODE+OPERAND-1:0]   o_mem_data,
    output logic                        o_mem_we,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [1:0]                  o_err,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_cpu_en
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = OPCODE + OPERAND;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OPCODE   = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;          // address of the next word
    logic [AW-1:0]   mem_addr_q, mem_addr_d;  // address presented with the write
    logic [W-1:0]    mem_data_q, mem_data_d;
    logic            we_q, we_d;
    logic            done_q, done_d;
    logic [1:0]      err_q, err_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      hi_q, hi_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        we_d       = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        count_d    = count_q;
        hi_d       = hi_q;
        tmo_d      = tmo_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_d    = S_WAIT_HI;
                    addr_d     = '0;
                    mem_addr_d = '0;
                    count_d    = '0;
                    err_d      = ERR_NONE;
                    done_d     = 1'b0;
                end
            end

            S_WAIT_HI: begin
                if (i_rx_valid) begin
                    // Legal opcodes are HLT..SUBI (0..7): bits [7:6] must be zero.
                    if (i_rx_data[7:6] != 2'b00) begin
                        state_d = S_ERROR;
                        err_d   = ERR_OPCODE;
                    end else begin
                        hi_d    = i_rx_data;
                        tmo_d   = '0;
                        state_d = S_WAIT_LO;
                    end
                end
            end

            S_WAIT_LO: begin
                if (i_rx_valid) begin
                    // The write is registered, so it appears in the cycle after
                    // the low byte while the FSM is already able to take the
                    // next high byte: back-to-back bytes lose nothing.
                    we_d       = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = W'({hi_q, i_rx_data});
                    count_d    = count_q + CNT_ONE;
                    if (hi_q[7:3] == 5'b00000) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (addr_q == ADDR_LAST) begin
                        state_d = S_ERROR;
                        err_d   = ERR_OVERFLOW;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_WAIT_HI;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // This is the TIMEOUT-th idle cycle since the high byte.
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
            count_q    <= '0;
            hi_q       <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
            hi_q       <= hi_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_mem_addr = mem_addr_q;
    assign o_mem_data = mem_data_q;
    assign o_mem_we   = we_q;
    assign o_busy     = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_count    = count_q;
    assign o_cpu_en   = done_q;

endmodule
